// File: rtl/pc_sequencer_if.sv
// Bus between the sequencer, instruction memory and the PC unit.
// Instruction-memory handshake: imem_req stays high for the whole FETCH phase
// and the word is consumed on the first cycle in which imem_ack is also high;
// imem_ack outside a request is ignored.
interface pc_sequencer_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              imem_req;
  logic              imem_ack;
  logic [1:0]        pc_ctrl;
  logic [ADDR_W-1:0] pc_target;
  logic [ADDR_W-1:0] pc_cur;

  modport master (
    output imem_req,
    input  imem_ack,
    output pc_ctrl,
    output pc_target,
    input  pc_cur
  );

  modport slave (
    input  imem_req,
    output imem_ack,
    input  pc_ctrl,
    input  pc_target,
    output pc_cur
  );
endinterface

// File: rtl/pc_sequencer.sv
// Instruction-cycle controller for the PC unit.
// Walks each instruction through FETCH, DECODE, EXEC and UPDATE.
// It drives the PC control code (00 hold, 01 increment, 10 load, 11 clear).
// Optional interrupt entry/return support is enabled by defining PC_SEQ_IRQ_EN.
module pc_sequencer #(
  parameter int unsigned       ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] IRQ_VECTOR = 16'h0004,
  parameter int unsigned       CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  pc_sequencer_if.master    bus,
  input  logic              stall,
  input  logic              is_halt,
  input  logic              is_jump,
  input  logic              is_branch,
  input  logic              br_taken,
  input  logic              is_reti,
  input  logic              irq,
  input  logic [ADDR_W-1:0] jump_reg,
  input  logic [ADDR_W-1:0] br_target,
  output logic              ir_load,
  output logic              dec_en,
  output logic              ex_en,
  output logic              halted,
  output logic [CNT_W-1:0]  retired,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_CLR    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_UPDATE = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [1:0] PC_HOLD  = 2'b00;
  localparam logic [1:0] PC_INC   = 2'b01;
  localparam logic [1:0] PC_LOAD  = 2'b10;
  localparam logic [1:0] PC_CLEAR = 2'b11;

  state_t            state_q, state_d;
  logic              dec_load_q;
  logic [ADDR_W-1:0] target_q;

  logic              take_halt;
  logic              take_load;
  logic [ADDR_W-1:0] take_tgt;
  logic              ex_done;
  logic              irq_take;

  logic              imem_req_c;
  logic [1:0]        pc_ctrl_c;
  logic [ADDR_W-1:0] pc_target_c;

`ifdef PC_SEQ_IRQ_EN
  logic              take_reti;
  logic              dec_reti_q;
  logic              in_isr_q;
  logic [ADDR_W-1:0] epc_q;
`else
  logic              unused_irq_inputs;
  assign unused_irq_inputs = ^{irq, is_reti, bus.pc_cur};
`endif

  assign ex_done   = (state_q == S_EXEC) && !stall;
  assign ir_load   = (state_q == S_FETCH) && bus.imem_ack;
  assign dbg_state = state_q;

  assign bus.imem_req  = imem_req_c;
  assign bus.pc_ctrl   = pc_ctrl_c;
  assign bus.pc_target = pc_target_c;

`ifdef PC_SEQ_IRQ_EN
  // Interrupt entry is possible only from UPDATE or HALT when not already in a handler.
  assign irq_take = irq && !in_isr_q && ((state_q == S_UPDATE) || (state_q == S_HALT));
`else
  assign irq_take = 1'b0;
`endif

  // Resolve the control-flow decision from the decoder/ALU flags, highest priority first.
  always_comb begin
    take_halt = 1'b0;
    take_load = 1'b0;
    take_tgt  = '0;
`ifdef PC_SEQ_IRQ_EN
    take_reti = 1'b0;
`endif
    if (is_halt) begin
      take_halt = 1'b1;
    end
`ifdef PC_SEQ_IRQ_EN
    else if (is_reti) begin
      take_load = 1'b1;
      take_reti = 1'b1;
      take_tgt  = epc_q;
    end
`endif
    else if (is_jump) begin
      take_load = 1'b1;
      take_tgt  = jump_reg;
    end else if (is_branch && br_taken) begin
      take_load = 1'b1;
      take_tgt  = br_target;
    end
  end

  // Next-state and phase outputs; outputs come from state and the decision register.
  always_comb begin
    state_d     = state_q;
    imem_req_c  = 1'b0;
    dec_en      = 1'b0;
    ex_en       = 1'b0;
    halted      = 1'b0;
    pc_ctrl_c   = PC_HOLD;
    pc_target_c = '0;
    case (state_q)
      S_CLR: begin
        pc_ctrl_c = PC_CLEAR;
        state_d   = S_FETCH;
      end
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (bus.imem_ack) state_d = S_DECODE;
      end
      S_DECODE: begin
        dec_en  = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        ex_en = 1'b1;
        if (!stall) state_d = take_halt ? S_HALT : S_UPDATE;
      end
      S_UPDATE: begin
        if (irq_take) begin
          pc_ctrl_c   = PC_LOAD;
          pc_target_c = IRQ_VECTOR;
        end else if (dec_load_q) begin
          pc_ctrl_c   = PC_LOAD;
          pc_target_c = target_q;
        end else begin
          pc_ctrl_c = PC_INC;
        end
        state_d = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        if (irq_take) begin
          pc_ctrl_c   = PC_LOAD;
          pc_target_c = IRQ_VECTOR;
          state_d     = S_FETCH;
        end
      end
      default: state_d = S_CLR;
    endcase
  end

  // State register, latched decision and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_CLR;
      dec_load_q <= 1'b0;
      target_q   <= '0;
      retired    <= '0;
    end else begin
      state_q <= state_d;
      if (ex_done) begin
        dec_load_q <= take_load;
        target_q   <= take_tgt;
      end
      if ((state_q == S_UPDATE) || (ex_done && take_halt)) begin
        retired <= retired + CNT_W'(1);
      end
    end
  end

`ifdef PC_SEQ_IRQ_EN
  // Handler bookkeeping: capture the return address on entry, leave on a retired reti.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_reti_q <= 1'b0;
      in_isr_q   <= 1'b0;
      epc_q      <= '0;
    end else begin
      if (ex_done) dec_reti_q <= take_reti;
      if (irq_take) begin
        in_isr_q <= 1'b1;
        epc_q    <= ((state_q == S_HALT) || !dec_load_q) ? (bus.pc_cur + ADDR_W'(1)) : target_q;
      end else if ((state_q == S_UPDATE) && dec_reti_q) begin
        in_isr_q <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer.
// Each record drives one cycle of inputs and lists the outputs expected in that cycle.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, is_halt, is_jump, is_branch, br_taken, is_reti, irq;
  logic [15:0] jump_reg, br_target;
  logic        ir_load, dec_en, ex_en, halted;
  logic [31:0] retired;
  logic [2:0]  dbg_state;

  pc_sequencer_if #(.ADDR_W(16)) bus ();

  pc_sequencer #(.ADDR_W(16), .IRQ_VECTOR(16'h0004), .CNT_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .stall     (stall),
    .is_halt   (is_halt),
    .is_jump   (is_jump),
    .is_branch (is_branch),
    .br_taken  (br_taken),
    .is_reti   (is_reti),
    .irq       (irq),
    .jump_reg  (jump_reg),
    .br_target (br_target),
    .ir_load   (ir_load),
    .dec_en    (dec_en),
    .ex_en     (ex_en),
    .halted    (halted),
    .retired   (retired),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ack;
    logic        stall;
    logic [5:0]  flags;   // {halt, jump, branch, taken, reti, irq}
    logic [15:0] jreg;
    logic [15:0] btgt;
    logic [3:0]  strb;    // {imem_req, ir_load, dec_en, ex_en}
    logic [1:0]  ctrl;
    logic [15:0] tgt;
    logic        hlt;
    logic [31:0] ret;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic add(input logic r, input logic a, input logic s, input logic [5:0] f,
                     input logic [15:0] jr, input logic [15:0] bt, input logic [3:0] st,
                     input logic [1:0] c, input logic [15:0] t, input logic h,
                     input logic [31:0] n);
    vec_t v;
    v.rst = r; v.ack = a; v.stall = s; v.flags = f; v.jreg = jr; v.btgt = bt;
    v.strb = st; v.ctrl = c; v.tgt = t; v.hlt = h; v.ret = n;
    vecs.push_back(v);
  endtask

  // Driver: apply one record's inputs
  task automatic drive(input vec_t v);
    rst          = v.rst;
    bus.imem_ack = v.ack;
    stall        = v.stall;
    {is_halt, is_jump, is_branch, br_taken, is_reti, irq} = v.flags;
    jump_reg     = v.jreg;
    br_target    = v.btgt;
  endtask

  // Scoreboard: compare every output of the current cycle against the record
  task automatic check(input int idx, input vec_t v);
    logic [54:0] act, exp;
    act = {bus.imem_req, ir_load, dec_en, ex_en, bus.pc_ctrl, bus.pc_target, halted, retired};
    exp = {v.strb, v.ctrl, v.tgt, v.hlt, v.ret};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL vec%0d state=%0d got req/irl/dec/ex=%b ctrl=%b tgt=%h halted=%b retired=%0d; want req/irl/dec/ex=%b ctrl=%b tgt=%h halted=%b retired=%0d",
               idx, dbg_state, act[54:51], act[50:49], act[48:33], act[32], act[31:0],
               v.strb, v.ctrl, v.tgt, v.hlt, v.ret);
    end
  endtask

  initial begin
    rst = 1'b1; bus.imem_ack = 1'b0; bus.pc_cur = 16'h0010;
    stall = 0; is_halt = 0; is_jump = 0; is_branch = 0; br_taken = 0; is_reti = 0; irq = 0;
    jump_reg = '0; br_target = '0;

    // Reset held, then release: clear code throughout plus one CLR cycle.
    add(1,0,0,6'b000000,16'h0,16'h0,4'b0000,2'b11,16'h0,0,0);
    add(1,0,0,6'b000000,16'h0,16'h0,4'b0000,2'b11,16'h0,0,0);
    add(0,0,0,6'b000000,16'h0,16'h0,4'b0000,2'b11,16'h0,0,0);
    // Three plain instructions, ack on the first FETCH cycle.
    for (int k = 0; k < 3; k++) begin
      add(0,1,0,6'b000000,16'h0,16'h0,4'b1100,2'b00,16'h0,0,k);
      add(0,0,0,6'b000000,16'h0,16'h0,4'b0010,2'b00,16'h0,0,k);
      add(0,0,0,6'b000000,16'h0,16'h0,4'b0001,2'b00,16'h0,0,k);
      add(0,0,0,6'b000000,16'h0,16'h0,4'b0000,2'b01,16'h0,0,k);
    end
    // Ack two cycles late, stall three cycles with a jump flag that must be ignored: 9 cycles.
    add(0,0,0,6'b000000,16'h0,16'h0,4'b1000,2'b00,16'h0,0,3);
    add(0,0,0,6'b000000,16'h0,16'h0,4'b1000,2'b00,16'h0,0,3);
    add(0,1,0,6'b000000,16'h0,16'h0,4'b1100,2'b00,16'h0,0,3);
    add(0,1,0,6'b000000,16'h0,16'h0,4'b0010,2'b00,16'h0,0,3);
    add(0,0,1,6'b010000,16'h0bad,16'h0,4'b0001,2'b00,16'h0,0,3);
    add(0,0,1,6'b010000,16'h0bad,16'h0,4'b0001,2'b00,16'h0,0,3);
    add(0,0,1,6'b010000,16'h0bad,16'h0,4'b0001,2'b00,16'h0,0,3);
    add(0,0,0,6'b000000,16'h0,16'h0,4'b0001,2'b00,16'h0,0,3);
    add(0,0,0,6'b000000,16'h0,16'h0,4'b0000,2'b01,16'h0,0,3);
    // Taken branch loads br_target.
    add(0,1,0,6'b000000,16'h0,16'h0,4'b1100,2'b00,16'h0,0,4);
    add(0,0,0,6'b000000,16'h0,16'h0,4'b0010,2'b00,16'h0,0,4);
    add(0,0,0,6'b001100,16'h1234,16'h0040,4'b0001,2'b00,16'h0,0,4);
    add(0,0,0,6'b000000,16'h0,16'h0,4'b0000,2'b10,16'h0040,0,4);
    // Same branch not taken increments.
    add(0,1,0,6'b000000,16'h0,16'h0,4'b1100,2'b00,16'h0,0,5);
    add(0,0,0,6'b000000,16'h0,16'h0,4'b0010,2'b00,16'h0,0,5);
    add(0,0,0,6'b001000,16'h0,16'h0040,4'b0001,2'b00,16'h0,0,5);
    add(0,0,0,6'b000000,16'h0,16'h0,4'b0000,2'b01,16'h0,0,5);
    // Jump wins over a taken branch.
    add(0,1,0,6'b000000,16'h0,16'h0,4'b1100,2'b00,16'h0,0,6);
    add(0,0,0,6'b000000,16'h0,16'h0,4'b0010,2'b00,16'h0,0,6);
    add(0,0,0,6'b011100,16'h0abc,16'h0040,4'b0001,2'b00,16'h0,0,6);
    add(0,0,0,6'b000000,16'h0,16'h0,4'b0000,2'b10,16'h0abc,0,6);
    // Halt wins over jump; HALT holds, ignores ack, and is left only by rst.
    add(0,1,0,6'b000000,16'h0,16'h0,4'b1100,2'b00,16'h0,0,7);
    add(0,0,0,6'b000000,16'h0,16'h0,4'b0010,2'b00,16'h0,0,7);
    add(0,0,0,6'b110000,16'h0abc,16'h0,4'b0001,2'b00,16'h0,0,7);
    add(0,0,0,6'b000000,16'h0,16'h0,4'b0000,2'b00,16'h0,1,8);
    add(0,1,0,6'b000000,16'h0,16'h0,4'b0000,2'b00,16'h0,1,8);
    add(1,0,0,6'b000000,16'h0,16'h0,4'b0000,2'b00,16'h0,1,8);
    add(0,0,0,6'b000000,16'h0,16'h0,4'b0000,2'b11,16'h0,0,0);
    // Reset during a stalled jump: no retire, no load.
    add(0,1,0,6'b000000,16'h0,16'h0,4'b1100,2'b00,16'h0,0,0);
    add(0,0,0,6'b000000,16'h0,16'h0,4'b0010,2'b00,16'h0,0,0);
    add(0,0,1,6'b010000,16'h0055,16'h0,4'b0001,2'b00,16'h0,0,0);
    add(1,0,1,6'b010000,16'h0055,16'h0,4'b0001,2'b00,16'h0,0,0);
    add(0,0,0,6'b000000,16'h0,16'h0,4'b0000,2'b11,16'h0,0,0);
    add(0,0,0,6'b000000,16'h0,16'h0,4'b1000,2'b00,16'h0,0,0);
`ifdef PC_SEQ_IRQ_EN
    // irq in UPDATE of an increment at pc_cur=0010 enters the handler.
    add(0,1,0,6'b000000,16'h0,16'h0,4'b1100,2'b00,16'h0,0,0);
    add(0,0,0,6'b000000,16'h0,16'h0,4'b0010,2'b00,16'h0,0,0);
    add(0,0,0,6'b000000,16'h0,16'h0,4'b0001,2'b00,16'h0,0,0);
    add(0,0,0,6'b000001,16'h0,16'h0,4'b0000,2'b10,16'h0004,0,0);
    // A second irq inside the handler is ignored.
    add(0,1,0,6'b000000,16'h0,16'h0,4'b1100,2'b00,16'h0,0,1);
    add(0,0,0,6'b000000,16'h0,16'h0,4'b0010,2'b00,16'h0,0,1);
    add(0,0,0,6'b000000,16'h0,16'h0,4'b0001,2'b00,16'h0,0,1);
    add(0,0,0,6'b000001,16'h0,16'h0,4'b0000,2'b01,16'h0,0,1);
    // reti returns to the captured address 0011.
    add(0,1,0,6'b000000,16'h0,16'h0,4'b1100,2'b00,16'h0,0,2);
    add(0,0,0,6'b000000,16'h0,16'h0,4'b0010,2'b00,16'h0,0,2);
    add(0,0,0,6'b000010,16'h0,16'h0,4'b0001,2'b00,16'h0,0,2);
    add(0,0,0,6'b000000,16'h0,16'h0,4'b0000,2'b10,16'h0011,0,2);
    add(0,0,0,6'b000000,16'h0,16'h0,4'b1000,2'b00,16'h0,0,3);
`endif

    repeat (2) @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      #1;
      drive(vecs[i]);
      @(negedge clk);
      check(i, vecs[i]);
      @(posedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
